// File: rtl/sync_pkg.sv
// Shared definitions for clock-domain-crossing blocks: handshake FSM states,
// legal synchronizer depth range and the default bus width.
package sync_pkg;

    // Two-state receive handshake FSM, binary encoded.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } sync_state_e;

    localparam int SYNC_MIN_STAGES        = 2;
    localparam int SYNC_MAX_STAGES        = 4;
    localparam int SYNC_DEFAULT_BUS_WIDTH = 8;

    // The single-word output slot may take a new word when it is empty or
    // when its current word is being consumed on the same edge.
    function automatic logic slot_free(input logic valid, input logic ready);
        return (!valid) || ready;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single-bit level crossing into clk.
// Resets asynchronously to 0; output is the last flop of the chain.
module sync_ff_chain
    import sync_pkg::*;
#(
    parameter int NUM_STAGES = SYNC_MIN_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [NUM_STAGES-1:0] sync_q;

    // Shift the asynchronous level through the chain, one stage per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {NUM_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/hs_data_sync_rx.sv
// Receive side of a four-phase req/ack bus crossing. The request level is
// synchronized, the source bus is sampled once on acceptance, and the word
// is offered to local logic through a single valid/ready slot. The ack level
// back to the source comes straight from a flop.
module hs_data_sync_rx
    import sync_pkg::*;
#(
    parameter int BUS_WIDTH  = SYNC_DEFAULT_BUS_WIDTH,
    parameter int NUM_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_async,
    input  logic [BUS_WIDTH-1:0] data_async,
    output logic                 ack,
    output logic [BUS_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 busy
);

    if ((NUM_STAGES < SYNC_MIN_STAGES) || (NUM_STAGES > SYNC_MAX_STAGES)) begin : g_bad_stages
        $error("hs_data_sync_rx: NUM_STAGES must be within 2..4");
    end

    logic                 req_sync_s;
    logic                 slot_free_s;
    logic                 capture_s;
    sync_state_e          state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic [BUS_WIDTH-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;

    sync_ff_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (req_async),
        .q_o   (req_sync_s)
    );

    // Handshake FSM: accept a request only when the slot can take the word,
    // otherwise hold ack low so the source keeps req and data steady.
    always_comb begin
        slot_free_s = slot_free(dout_valid_q, dout_ready);
        capture_s   = 1'b0;
        state_d     = state_q;
        ack_d       = ack_q;
        case (state_q)
            IDLE: begin
                if (req_sync_s && slot_free_s) begin
                    capture_s = 1'b1;
                    state_d   = ACK;
                    ack_d     = 1'b1;
                end else begin
                    ack_d     = 1'b0;
                end
            end
            ACK: begin
                if (!req_sync_s) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end else begin
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
        busy_d = (state_d == ACK);
    end

    // Output slot: a capture wins over a consume so that capture-and-consume
    // on one edge refills the slot without a bubble.
    always_comb begin
        if (capture_s) begin
            dout_d       = data_async;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_d       = dout_q;
            dout_valid_d = 1'b0;
        end else begin
            dout_d       = dout_q;
            dout_valid_d = dout_valid_q;
        end
    end

    // State, ack and slot registers; reset drops ack and discards the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            dout_q       <= {BUS_WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign ack        = ack_q;
    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: doc/hs_data_sync_rx.md
Name: hs_data_sync_rx

Overview:
- Receive end of the four-phase req/ack bus-crossing handshake. Complements the reset synchronizer in the sync directory.
- Accepts a level request `req_async` and a bus `data_async` from a foreign clock domain.
- Synchronizes the request through a multi-flop chain, captures the bus once it is stable, and returns a registered `ack` level to the source.
- Presents captured words to local logic (ALU/register file side of the UART system) through a valid/ready output slot.

Parameters:
- BUS_WIDTH, 8, width of `data_async` and `dout`.
- NUM_STAGES, 2, flops in the request synchronizer chain; legal range 2..4. Values outside this range must stop elaboration with `$error`.

Ports:
- clk  in  1  destination-domain clock.
- rst  in  1  asynchronous, active-low reset.
- req_async  in  1  request level from source domain; unsynchronized.
- data_async  in  BUS_WIDTH  source bus; the source holds it stable from `req` rise until `ack` is seen high.
- ack  out  1  acknowledge level to source; a direct flop output with no logic after the register.
- dout  out  BUS_WIDTH  captured word.
- dout_valid  out  1  `dout` holds an unconsumed word.
- dout_ready  in  1  local consumer accepts `dout` when `dout_valid`=1.
- busy  out  1  high while state ≠ IDLE.

Behaviour:
- Reset (rst=0, asynchronous): sync chain=0, state=IDLE, ack=0, dout=0, dout_valid=0, busy=0. Release is synchronous to clk; rst is driven from the rst_sync output.
- req_sync = last stage of the NUM_STAGES chain.
- Latency: `req_async` rising before edge k gives req_sync high after edge k+NUM_STAGES-1.
- Slot free = (dout_valid==0) or (dout_valid && dout_ready).
- State machine, 2 states, binary encoded:
  - IDLE: ack=0.
    - If req_sync=1 and slot free: on that edge dout<=data_async, dout_valid<=1, ack<=1, state->ACK.
    - If req_sync=1 and slot not free: stay in IDLE and hold ack=0. This is back-pressure; the source keeps req high and data stable.
  - ACK: ack=1, busy=1. When req_sync=0: ack<=0, state->IDLE.
- `data_async` is sampled only on the IDLE->ACK edge and is never passed through the sync chain.
- Output slot:
  - `dout_valid` clears on an edge with dout_valid && dout_ready and no capture on the same edge.
  - Capture and consume on the same edge: new word loaded, dout_valid stays 1, no bubble and no loss.
- `dout` holds its value while dout_valid=0. `dout` must not change while dout_valid=1 and dout_ready=0.
- Glitch on req_async shorter than one clk: captured or ignored, no further requirement. The source protocol forbids such glitches.
- Reset mid-handshake (state=ACK, req still high):
  - ack drops asynchronously and the word in the slot is lost.
  - After release, if req_sync is still 1, a second capture of the same word occurs. This duplicate is accepted behaviour and the source must tolerate it.
- Throughput ceiling is one word per (2·NUM_STAGES + source sync latency) cycles. This is not a FIFO.

Decomposition:
- Package `sync_pkg`:
  - state enum {IDLE, ACK};
  - constants SYNC_MIN_STAGES=2 and SYNC_MAX_STAGES=4;
  - default BUS_WIDTH localparam.
- One sub-module `sync_ff_chain`:
  - parameterized NUM_STAGES, 1-bit, async active-low reset to 0;
  - shared with future single-bit crossings.
- FSM and output slot stay in the top module.

Test Plan:
- Reset: hold rst=0 with req_async=1 for 5 cycles -> ack=0, dout_valid=0, dout=0, busy=0 throughout. After release, first capture occurs NUM_STAGES edges later.
- Single transfer:
  - stimulus: NUM_STAGES=2, dout_ready=1, data_async=8'hA5, req_async raised before edge 0;
  - req_sync high after edge 1, capture on edge 2 -> dout=8'hA5, dout_valid=1, ack=1;
  - drop req -> ack=0 two edges after req_sync falls path completes, busy=0.
- Back-pressure:
  - stimulus: dout_ready=0, first word 8'h11 delivered, second handshake with 8'h22;
  - while blocked -> ack stays 0, dout=8'h11 stable;
  - raise dout_ready for 1 cycle -> same-edge capture, dout=8'h22, dout_valid stays 1.
- Back-to-back: 16 handshakes with modelled source (its own 2-flop ack sync), data 0x00..0x0F -> consumer receives 0x00..0x0F in order, no duplicates, no drops.
- Reset in ACK state: assert rst while ack=1 and req high -> ack=0 immediately (asynchronous). After release the same word is captured once more, and ack re-asserts.
- Parameter sweep: NUM_STAGES=3 and 4 with BUS_WIDTH=16 (word 16'hBEEF) -> req-to-capture latency equals NUM_STAGES edges, data intact.
